// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared source indices, entry layout and round-robin helper for the writeback arbiter
package wb_pkg;

  localparam int NUM_SRC = 3;
  localparam int REG_W   = 5;

  typedef logic [1:0] src_t;

  localparam src_t SRC_X = 2'd0;
  localparam src_t SRC_M = 2'd1;
  localparam src_t SRC_L = 2'd2;

  // Entry layout at the default 32-bit data width; the top packs the same fields at DATA_W.
  typedef struct packed {
    logic [REG_W-1:0] regdest;
    logic [31:0]      wbvalue;
  } wb_entry_t;

  function automatic src_t next_src(input src_t s);
    return (s == SRC_L) ? SRC_X : s + 2'd1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source writeback FIFO with wrap-bit pointers and same-cycle push/pop on full
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees the slot this same edge, so a push onto a full FIFO is still accepted.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges X/M/L writebacks onto one register-file port; WB_STATS_EN adds counters
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        x_wb_regdest,
  input  logic              x_wb_writereg,
  input  logic [DATA_W-1:0] x_wb_wbvalue,
  input  logic [4:0]        m_wb_regdest,
  input  logic              m_wb_writereg,
  input  logic [DATA_W-1:0] m_wb_wbvalue,
  input  logic [4:0]        l_wb_regdest,
  input  logic              l_wb_writereg,
  input  logic [DATA_W-1:0] l_wb_wbvalue,
  output logic [4:0]        wb_rf_writeaddr,
  output logic              wb_rf_writeenable,
  output logic [DATA_W-1:0] wb_rf_writedata,
  output logic              wb_overflow
`ifdef WB_STATS_EN
  ,
  output logic [15:0]       wb_stat_writes,
  output logic [15:0]       wb_stat_waits
`endif
);

  localparam int ENTRY_W = REG_W + DATA_W;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [ENTRY_W-1:0] din  [NUM_SRC];
  logic [ENTRY_W-1:0] head [NUM_SRC];
  logic [ENTRY_W-1:0] win_entry;
  logic               grant_any;
  src_t               gsel;
  src_t               rr_ptr;

  // Register 0 is never a real destination, so it is filtered before buffering.
  assign push[SRC_X] = x_wb_writereg && (x_wb_regdest != 5'd0);
  assign push[SRC_M] = m_wb_writereg && (m_wb_regdest != 5'd0);
  assign push[SRC_L] = l_wb_writereg && (l_wb_regdest != 5'd0);
  assign din[SRC_X]  = {x_wb_regdest, x_wb_wbvalue};
  assign din[SRC_M]  = {m_wb_regdest, m_wb_wbvalue};
  assign din[SRC_L]  = {l_wb_regdest, l_wb_wbvalue};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    wb_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[i]),
      .pop   (grant[i]),
      .din   (din[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    gsel      = SRC_X;
    for (int i = 0; i < NUM_SRC; i++) begin
      int k;
      k = int'(rr_ptr) + i;
      if (k >= NUM_SRC) k = k - NUM_SRC;
      if (!grant_any && !empty[k]) begin
        grant_any = 1'b1;
        grant[k]  = 1'b1;
        gsel      = k[1:0];
      end
    end
  end

  assign win_entry = head[gsel];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr            <= SRC_X;
      wb_rf_writeenable <= 1'b0;
      wb_rf_writeaddr   <= '0;
      wb_rf_writedata   <= '0;
      wb_overflow       <= 1'b0;
    end else begin
      wb_rf_writeenable <= grant_any;
      if (grant_any) begin
        wb_rf_writeaddr <= win_entry[ENTRY_W-1:DATA_W];
        wb_rf_writedata <= win_entry[DATA_W-1:0];
        rr_ptr          <= next_src(gsel);
      end else begin
        wb_rf_writeaddr <= '0;
        wb_rf_writedata <= '0;
      end
      if (|(push & full & ~grant)) wb_overflow <= 1'b1;
    end
  end

`ifdef WB_STATS_EN
  logic waiting;

  // A source waits when it holds data this cycle but lost arbitration.
  assign waiting = |(~empty & ~grant);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_stat_writes <= '0;
      wb_stat_waits  <= '0;
    end else begin
      if (grant_any && (wb_stat_writes != 16'hFFFF)) wb_stat_writes <= wb_stat_writes + 16'd1;
      if (waiting && (wb_stat_waits != 16'hFFFF))    wb_stat_waits  <= wb_stat_waits + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  x_wb_regdest = '0, m_wb_regdest = '0, l_wb_regdest = '0;
  logic        x_wb_writereg = 1'b0, m_wb_writereg = 1'b0, l_wb_writereg = 1'b0;
  logic [31:0] x_wb_wbvalue = '0, m_wb_wbvalue = '0, l_wb_wbvalue = '0;
  logic [4:0]  wb_rf_writeaddr;
  logic        wb_rf_writeenable;
  logic [31:0] wb_rf_writedata;
  logic        wb_overflow;
`ifdef WB_STATS_EN
  logic [15:0] wb_stat_writes;
  logic [15:0] wb_stat_waits;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] wr_log [$];

  always #5 clock = ~clock;

  writeback_arbiter #(.DEPTH(4), .DATA_W(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .x_wb_regdest      (x_wb_regdest),
    .x_wb_writereg     (x_wb_writereg),
    .x_wb_wbvalue      (x_wb_wbvalue),
    .m_wb_regdest      (m_wb_regdest),
    .m_wb_writereg     (m_wb_writereg),
    .m_wb_wbvalue      (m_wb_wbvalue),
    .l_wb_regdest      (l_wb_regdest),
    .l_wb_writereg     (l_wb_writereg),
    .l_wb_wbvalue      (l_wb_wbvalue),
    .wb_rf_writeaddr   (wb_rf_writeaddr),
    .wb_rf_writeenable (wb_rf_writeenable),
    .wb_rf_writedata   (wb_rf_writedata),
    .wb_overflow       (wb_overflow)
`ifdef WB_STATS_EN
    ,
    .wb_stat_writes    (wb_stat_writes),
    .wb_stat_waits     (wb_stat_waits)
`endif
  );

  always @(negedge clock) begin
    if (reset && wb_rf_writeenable) wr_log.push_back({wb_rf_writeaddr, wb_rf_writedata});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int s, input logic [4:0] r, input logic w, input logic [31:0] v);
    case (s)
      0: begin x_wb_regdest = r; x_wb_writereg = w; x_wb_wbvalue = v; end
      1: begin m_wb_regdest = r; m_wb_writereg = w; m_wb_wbvalue = v; end
      default: begin l_wb_regdest = r; l_wb_writereg = w; l_wb_wbvalue = v; end
    endcase
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 3; s++) set_src(s, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int start;
    int hits;
    int bad_data;
    int bad_order;
    int last_r [3];
    logic [4:0] r5;

    // reset state and a single uncontended write
    do_reset();
    check_eq("rst_we", wb_rf_writeenable, 0);
    check_eq("rst_addr", wb_rf_writeaddr, 0);
    check_eq("rst_data", wb_rf_writedata, 0);
    check_eq("rst_ovf", wb_overflow, 0);
    set_src(0, 5'd5, 1'b1, 32'hDEADBEEF);
    tick();
    clear_inputs();
    check_eq("s1_not_fwd", wb_rf_writeenable, 0);
    tick();
    check_eq("s1_we", wb_rf_writeenable, 1);
    check_eq("s1_addr", wb_rf_writeaddr, 5);
    check_eq("s1_data", wb_rf_writedata, 32'hDEADBEEF);
    tick();
    check_eq("s1_we_once", wb_rf_writeenable, 0);
    check_eq("s1_addr_idle", wb_rf_writeaddr, 0);
    check_eq("s1_data_idle", wb_rf_writedata, 0);

    // three simultaneous writes drain X, M, L
    do_reset();
    set_src(0, 5'd1, 1'b1, 32'h11);
    set_src(1, 5'd2, 1'b1, 32'h22);
    set_src(2, 5'd3, 1'b1, 32'h33);
    tick();
    clear_inputs();
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq($sformatf("s2_we_%0d", i), wb_rf_writeenable, 1);
      check_eq($sformatf("s2_addr_%0d", i), wb_rf_writeaddr, i);
      check_eq($sformatf("s2_data_%0d", i), wb_rf_writedata, 32'h11 * i);
    end
    tick();
    check_eq("s2_idle", wb_rf_writeenable, 0);
`ifdef WB_STATS_EN
    check_eq("s6_writes", wb_stat_writes, 3);
    check_eq("s6_waits", wb_stat_waits, 2);
`endif
    // pointer back at X: X must beat M
    set_src(1, 5'd4, 1'b1, 32'h44);
    set_src(0, 5'd6, 1'b1, 32'h66);
    tick();
    clear_inputs();
    tick();
    check_eq("s2_ptr_first", wb_rf_writeaddr, 6);
    tick();
    check_eq("s2_ptr_second", wb_rf_writeaddr, 4);

    // ignored inputs
    do_reset();
    start = wr_log.size();
    set_src(0, 5'd0, 1'b1, 32'h1234);
    set_src(1, 5'd7, 1'b0, 32'h5678);
    tick();
    clear_inputs();
    repeat (3) tick();
    check_eq("s3_no_write", wr_log.size() - start, 0);
    check_eq("s3_no_ovf", wb_overflow, 0);

    // six cycles of pushes on every source: only L's sixth entry (reg 18) is dropped
    do_reset();
    start = wr_log.size();
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < 3; s++) begin
        r5 = 5'(s * 6 + c + 1);
        set_src(s, r5, 1'b1, 32'hC0DE0000 + 32'(r5));
      end
      tick();
      check_eq($sformatf("s4_ovf_c%0d", c), wb_overflow, (c == 5) ? 1 : 0);
    end
    clear_inputs();
    repeat (30) tick();
    check_eq("s4_ovf_sticky", wb_overflow, 1);
    check_eq("s4_total", wr_log.size() - start, 17);
    for (int r = 1; r <= 18; r++) begin
      hits = 0;
      for (int i = start; i < wr_log.size(); i++)
        if (int'(wr_log[i][36:32]) == r) hits++;
      check_eq($sformatf("s4_hits_r%0d", r), hits, (r == 18) ? 0 : 1);
    end
    bad_data  = 0;
    bad_order = 0;
    last_r    = '{0, 0, 0};
    for (int i = start; i < wr_log.size(); i++) begin
      int r;
      int s;
      r = int'(wr_log[i][36:32]);
      s = (r - 1) / 6;
      if (wr_log[i][31:0] != 32'hC0DE0000 + 32'(r)) bad_data++;
      if (s < 3) begin
        if (r <= last_r[s]) bad_order++;
        last_r[s] = r;
      end
    end
    check_eq("s4_data", bad_data, 0);
    check_eq("s4_order", bad_order, 0);

    // reset with entries buffered and overflow still set from the previous scenario
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 3; s++) set_src(s, 5'(20 + s * 2 + c), 1'b1, 32'hBEEF0000);
      tick();
    end
    clear_inputs();
    check_eq("s5_pre_we", wb_rf_writeenable, 1);
    start = wr_log.size();
    reset = 1'b0;
    #1;
    check_eq("s5_we", wb_rf_writeenable, 0);
    check_eq("s5_addr", wb_rf_writeaddr, 0);
    check_eq("s5_data", wb_rf_writedata, 0);
    check_eq("s5_ovf", wb_overflow, 0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check_eq("s5_no_write", wr_log.size() - start, 0);
    check_eq("s5_ovf_after", wb_overflow, 0);

`ifdef WB_STATS_EN
    // saturation of the write counter
    do_reset();
    force dut.wb_stat_writes = 16'hFFFE;
    #1;
    release dut.wb_stat_writes;
    for (int i = 0; i < 2; i++) begin
      set_src(0, 5'd9, 1'b1, 32'h99);
      tick();
      clear_inputs();
      tick();
      check_eq($sformatf("s6_sat_%0d", i), wb_stat_writes, 16'hFFFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
